// File: rtl/collapse_pkg.sv
// Shared types for the collapse read initiator: FSM states, response
// status encoding, command payload and datapath widths.
package collapse_pkg;

  localparam int unsigned TIME_W  = 8;
  localparam int unsigned VALUE_W = 8;
  localparam int unsigned DEV_W   = 4;
  localparam int unsigned ROLE_W  = 2;
  localparam int unsigned BASIS_W = 2;
  localparam int unsigned ATT_W   = 4;
  localparam int unsigned GAP_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_READ    = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_GAP     = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK          = 2'b00,
    RSP_DENIED      = 2'b01,
    RSP_NO_COLLAPSE = 2'b10,
    RSP_PAD_BLOCKED = 2'b11
  } rsp_status_t;

  // Command fields latched on accept and presented to the target.
  typedef struct packed {
    logic [DEV_W-1:0]   device_id;
    logic [ROLE_W-1:0]  role;
    logic [BASIS_W-1:0] basis;
    logic [VALUE_W-1:0] value;
  } cmd_t;

endpackage

// File: rtl/collapse_time_base.sv
// Free-running wrapping time base presented to the target as current time.
// Ports: clk, reset (async, active-high), time_count (wraps 255 -> 0).
module collapse_time_base
  import collapse_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [TIME_W-1:0] time_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) time_count <= '0;
    else       time_count <= time_count + TIME_W'(1);
  end

endmodule

// File: rtl/collapse_read_initiator.sv
// Issues an optional init plus up to MAX_ATTEMPTS read strobes to a
// metadata collapse register, spacing denied attempts by RETRY_GAP idle
// cycles, confirms the fuse and returns one status/value response.
// Ports: cmd_* request side (valid/ready), rsp_* response side
// (valid/ready), tgt_* strobes/metadata to the target and its responses.
module collapse_read_initiator
  import collapse_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 4,
  parameter int unsigned RETRY_GAP    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load,
  input  logic [VALUE_W-1:0] cmd_value,
  input  logic [DEV_W-1:0]   cmd_device_id,
  input  logic [ROLE_W-1:0]  cmd_role,
  input  logic [BASIS_W-1:0] cmd_basis,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [VALUE_W-1:0] rsp_value,
  output logic [ATT_W-1:0]   rsp_attempts,
  output logic               tgt_init,
  output logic               tgt_read,
  output logic [VALUE_W-1:0] tgt_value_in,
  output logic [DEV_W-1:0]   tgt_device_id,
  output logic [ROLE_W-1:0]  tgt_role,
  output logic [BASIS_W-1:0] tgt_basis,
  output logic [TIME_W-1:0]  tgt_current_time,
  input  logic [VALUE_W-1:0] tgt_value_out,
  input  logic               tgt_output_enable,
  input  logic               tgt_pad_enable,
  input  logic               tgt_fuse_fire
);

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [ATT_W-1:0]   attempt_q, attempt_d, attempt_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [VALUE_W-1:0] cap_value_q, cap_value_d;
  rsp_status_t        cap_status_q, cap_status_d;

  logic               cmd_ready_d, tgt_init_d, tgt_read_d, rsp_valid_d;
  rsp_status_t        rsp_status_d;
  logic [VALUE_W-1:0] rsp_value_d;
  logic [ATT_W-1:0]   rsp_attempts_d;

  collapse_time_base u_time_base (
    .clk        (clk),
    .reset      (reset),
    .time_count (tgt_current_time)
  );

  // Latched command drives the target; cleared on return to IDLE.
  assign tgt_device_id = cmd_q.device_id;
  assign tgt_role      = cmd_q.role;
  assign tgt_basis     = cmd_q.basis;
  assign tgt_value_in  = cmd_q.value;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      attempt_q    <= '0;
      gap_q        <= '0;
      cap_value_q  <= '0;
      cap_status_q <= RSP_OK;
      cmd_ready    <= 1'b1;
      tgt_init     <= 1'b0;
      tgt_read     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= 2'b00;
      rsp_value    <= '0;
      rsp_attempts <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      attempt_q    <= attempt_d;
      gap_q        <= gap_d;
      cap_value_q  <= cap_value_d;
      cap_status_q <= cap_status_d;
      cmd_ready    <= cmd_ready_d;
      tgt_init     <= tgt_init_d;
      tgt_read     <= tgt_read_d;
      rsp_valid    <= rsp_valid_d;
      rsp_status   <= 2'(rsp_status_d);
      rsp_value    <= rsp_value_d;
      rsp_attempts <= rsp_attempts_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    attempt_d    = attempt_q;
    gap_d        = gap_q;
    cap_value_d  = cap_value_q;
    cap_status_d = cap_status_q;
    attempt_inc  = attempt_q + ATT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.device_id = cmd_device_id;
          cmd_d.role      = cmd_role;
          cmd_d.basis     = cmd_basis;
          cmd_d.value     = cmd_value;
          attempt_d       = '0;
          gap_d           = '0;
          cap_value_d     = '0;
          cap_status_d    = RSP_OK;
          state_d         = cmd_load ? ST_LOAD : ST_READ;
        end
      end
      ST_LOAD: state_d = ST_READ;
      ST_READ: begin
        attempt_d = attempt_inc;
        if (tgt_output_enable && tgt_pad_enable) begin
          cap_value_d = tgt_value_out;
          state_d     = ST_CONFIRM;
        end else if (tgt_output_enable) begin
          // Pad path closed: the read value is never forwarded.
          cap_status_d = RSP_PAD_BLOCKED;
          cap_value_d  = '0;
          state_d      = ST_RESP;
        end else if (attempt_inc == ATT_W'(MAX_ATTEMPTS)) begin
          cap_status_d = RSP_DENIED;
          cap_value_d  = '0;
          state_d      = ST_RESP;
        end else begin
          // Count down RETRY_GAP-1 .. 0, giving RETRY_GAP idle cycles.
          gap_d   = GAP_W'(RETRY_GAP - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_READ;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_CONFIRM: begin
        cap_status_d = tgt_fuse_fire ? RSP_OK : RSP_NO_COLLAPSE;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cmd_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    cmd_ready_d    = (state_d == ST_IDLE);
    tgt_init_d     = (state_d == ST_LOAD);
    tgt_read_d     = (state_d == ST_READ);
    rsp_valid_d    = (state_d == ST_RESP);
    rsp_status_d   = RSP_OK;
    rsp_value_d    = '0;
    rsp_attempts_d = '0;
    if (rsp_valid_d) begin
      rsp_status_d   = cap_status_d;
      rsp_value_d    = cap_value_d;
      rsp_attempts_d = attempt_d;
    end
  end

endmodule
